rx_param_funcmod: RTL and testbench

//  Parametrised UART receive function module: next generation of the fixed 8-bit/115200 receiver.
//  - Runtime-selectable parity (none/even/odd) and compile-time data width and stop-bit count.
//  - Validates the start bit and reports parity and framing errors.
//  - Sits between the RXD pad and a control module that grants iCall and consumes oDone/oData.

---
 rtl/rx_param_pkg.sv | 31 +++
 rtl/rx_param_funcmod_sampler.sv | 73 +++++++
 rtl/rx_param_funcmod.sv | 151 +++++++++++++++
 tb/tb_rx_param_funcmod.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: state encoding, parity modes,
// counter-width and bit-voting helpers. The optional voter is enabled by RX_MAJORITY_EN.
package rx_param_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP   = 3'd4;
   localparam state_t DONE   = 3'd5;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Width of a counter that must hold 0..div-1; never narrower than one bit.
   function automatic int cntWidth(input int div);
      if (div <= 2) begin
         return 1;
      end else begin
         return $clog2(div);
      end
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_param_funcmod_sampler.sv
// Bit sampler: RXD synchroniser, baud counter and the decision pulse for each bit.
// With RX_MAJORITY_EN defined each decision is a 2-of-3 vote over the last three samples.
module rx_bit_sampler
   import rx_param_pkg::*;
#(
   parameter int BAUD_DIV = 434
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic RXD,
   input  logic clear,
   input  logic halfBit,
   output logic rxdSync,
   output logic bitValid,
   output logic bitVal
);

   localparam int CW = cntWidth(BAUD_DIV);
   localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   logic [1:0]    syncReg_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] decisionCount_s;
   logic          atDecision_s;

   // Two-flop synchroniser for the asynchronous serial line, idling high.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         syncReg_r <= 2'b11;
      end else begin
         syncReg_r <= {syncReg_r[0], RXD};
      end
   end

   assign rxdSync = syncReg_r[1];

   // Decision point: mid-bit of the start bit, end of every full bit period otherwise.
   always_comb begin
      decisionCount_s = halfBit ? HALF_LAST : FULL_LAST;
      atDecision_s    = (count_r == decisionCount_s);
      bitValid        = atDecision_s & ~clear;
   end

   // Baud counter restarts at every decision and whenever the FSM is idle or aborting.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         count_r <= {CW{1'b0}};
      end else if (clear || atDecision_s) begin
         count_r <= {CW{1'b0}};
      end else begin
         count_r <= count_r + CW'(1);
      end
   end

`ifdef RX_MAJORITY_EN
   logic [1:0] vote_r;

   // Two older samples; together with the current one they form the vote at count D.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         vote_r <= 2'b11;
      end else begin
         vote_r <= {vote_r[0], rxdSync};
      end
   end

   assign bitVal = majority3(vote_r[1], vote_r[0], rxdSync);
`else
   assign bitVal = rxdSync;
`endif

endmodule

// File: rtl/rx_param_funcmod.sv
// Parametrised UART receiver top: frame FSM, shift register, parity/framing checks and
// registered outputs. Optional RX_MAJORITY_EN enables majority voting in the bit sampler.
module rx_param_funcmod
   import rx_param_pkg::*;
#(
   parameter int BAUD_DIV  = 434,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic                 RXD,
   input  logic                 iCall,
   input  logic [1:0]           iParity,
   output logic                 oDone,
   output logic [DATA_BITS-1:0] oData,
   output logic                 oParityErr,
   output logic                 oFrameErr,
   output logic                 oBusy
);

   localparam int BW = cntWidth(DATA_BITS);

   state_t               state_r;
   logic [1:0]           parityMode_r;
   logic [DATA_BITS-1:0] shiftReg_r;
   logic [BW-1:0]        bitCnt_r;
   logic                 stopCnt_r;
   logic                 parityErr_r;
   logic                 frameErr_r;
   logic                 clear_s;
   logic                 halfBit_s;
   logic                 parityOn_s;
   logic                 rxdSync_s;
   logic                 bitValid_s;
   logic                 bitVal_s;

   function automatic logic parityBad(input logic [DATA_BITS-1:0] d, input logic b,
                                      input logic odd);
      return (^d ^ b) != odd;
   endfunction

   rx_bit_sampler #(.BAUD_DIV(BAUD_DIV)) u_sampler (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .RXD      (RXD),
      .clear    (clear_s),
      .halfBit  (halfBit_s),
      .rxdSync  (rxdSync_s),
      .bitValid (bitValid_s),
      .bitVal   (bitVal_s)
   );

   // Sampler control and parity enable derived from the current state.
   always_comb begin
      clear_s    = (state_r == IDLE) || (state_r == DONE) || !iCall;
      halfBit_s  = (state_r == START);
      parityOn_s = (parityMode_r == PAR_EVEN) || (parityMode_r == PAR_ODD);
   end

   // Frame FSM with the datapath and registered outputs.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_r      <= IDLE;
         parityMode_r <= PAR_NONE;
         shiftReg_r   <= {DATA_BITS{1'b0}};
         bitCnt_r     <= {BW{1'b0}};
         stopCnt_r    <= 1'b0;
         parityErr_r  <= 1'b0;
         frameErr_r   <= 1'b0;
         oDone        <= 1'b0;
         oData        <= {DATA_BITS{1'b0}};
         oParityErr   <= 1'b0;
         oFrameErr    <= 1'b0;
         oBusy        <= 1'b0;
      end else if (!iCall) begin
         state_r <= IDLE;
         oDone   <= 1'b0;
         oBusy   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               oDone <= 1'b0;
               if (!rxdSync_s) begin
                  state_r      <= START;
                  parityMode_r <= iParity;
                  bitCnt_r     <= {BW{1'b0}};
                  stopCnt_r    <= 1'b0;
                  parityErr_r  <= 1'b0;
                  frameErr_r   <= 1'b0;
                  oBusy        <= 1'b1;
               end
            end
            START: begin
               if (bitValid_s) begin
                  if (!bitVal_s) begin
                     state_r <= DATA;
                  end else begin
                     state_r <= IDLE;
                     oBusy   <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (bitValid_s) begin
                  shiftReg_r <= {bitVal_s, shiftReg_r[DATA_BITS-1:1]};
                  if (bitCnt_r == BW'(DATA_BITS - 1)) begin
                     state_r <= parityOn_s ? PARITY : STOP;
                  end else begin
                     bitCnt_r <= bitCnt_r + BW'(1);
                  end
               end
            end
            PARITY: begin
               if (bitValid_s) begin
                  parityErr_r <= parityBad(shiftReg_r, bitVal_s, parityMode_r == PAR_ODD);
                  state_r     <= STOP;
               end
            end
            STOP: begin
               if (bitValid_s) begin
                  if (!bitVal_s) begin
                     frameErr_r <= 1'b1;
                  end
                  // Last stop bit: publish the frame as DONE is entered.
                  if (stopCnt_r == 1'(STOP_BITS - 1)) begin
                     state_r    <= DONE;
                     oDone      <= 1'b1;
                     oData      <= shiftReg_r;
                     oParityErr <= parityErr_r;
                     oFrameErr  <= frameErr_r | ~bitVal_s;
                  end else begin
                     stopCnt_r <= stopCnt_r + 1'b1;
                  end
               end
            end
            DONE: begin
               state_r <= IDLE;
               oDone   <= 1'b0;
               oBusy   <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               oDone   <= 1'b0;
               oBusy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_param_funcmod.sv
// Scoreboard bench for rx_param_funcmod at BAUD_DIV=16, 8 data bits, 1 stop bit.
// The glitch scenario runs only when RX_MAJORITY_EN is defined.
module tb_rx_param_funcmod;

   localparam int B    = 16;
   localparam int HALF = B / 2;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic       RXD;
   logic       iCall;
   logic [1:0] iParity;
   logic       oDone;
   logic [7:0] oData;
   logic       oParityErr;
   logic       oFrameErr;
   logic       oBusy;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t expQ[$];
   exp_t monExp;
   int   total = 0;
   int   bad = 0;
   int   cycleCnt = 0;
   int   fallCycle = 0;
   int   doneCount = 0;
   int   doneLatency = 0;

   rx_param_funcmod #(.BAUD_DIV(B), .DATA_BITS(8), .STOP_BITS(1)) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .RXD        (RXD),
      .iCall      (iCall),
      .iParity    (iParity),
      .oDone      (oDone),
      .oData      (oData),
      .oParityErr (oParityErr),
      .oFrameErr  (oFrameErr),
      .oBusy      (oBusy)
   );

   always #5 CLOCK = ~CLOCK;

   initial forever begin
      @(posedge CLOCK);
      cycleCnt++;
   end

   // Output monitor: every oDone pulse pops one expected frame.
   initial forever begin
      @(negedge CLOCK);
      if (oDone === 1'b1) begin
         doneCount++;
         doneLatency = cycleCnt - fallCycle;
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: got oDone=1 oData=%h, required no frame", oData);
         end else begin
            monExp = expQ.pop_front();
            if ({oData, oParityErr, oFrameErr} !== {monExp.d, monExp.pe, monExp.fe}) begin
               bad++;
               $display("FAIL frame: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                        oData, oParityErr, oFrameErr, monExp.d, monExp.pe, monExp.fe);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic idle(input int n);
      RXD = 1'b1;
      repeat (n) @(posedge CLOCK);
      #1;
   endtask

   task automatic holdBit(input logic v);
      RXD = v;
      repeat (B) @(posedge CLOCK);
      #1;
   endtask

   // One frame starting just after a rising edge; glitchBit>=0 adds a 1-cycle high pulse.
   task automatic sendFrame(input logic [7:0] d, input logic hasPar, input logic pbit,
                            input logic stopBit, input int glitchBit);
      RXD = 1'b0;
      fallCycle = cycleCnt;
      repeat (B) @(posedge CLOCK);
      #1;
      for (int i = 0; i < 8; i++) begin
         if (i == glitchBit) begin
            RXD = d[i];
            repeat (HALF) @(posedge CLOCK);
            #1;
            RXD = 1'b1;
            @(posedge CLOCK);
            #1;
            RXD = d[i];
            repeat (B - HALF - 1) @(posedge CLOCK);
            #1;
         end else begin
            holdBit(d[i]);
         end
      end
      if (hasPar) holdBit(pbit);
      holdBit(stopBit);
   endtask

   // Start bit plus bits 0..3, then half of bit 4.
   task automatic sendPartial(input logic [7:0] d);
      holdBit(1'b0);
      for (int i = 0; i < 4; i++) holdBit(d[i]);
      RXD = d[4];
      repeat (HALF) @(posedge CLOCK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1; RXD = 1'b1; iCall = 1'b1; iParity = 2'b00;
      repeat (3) @(posedge CLOCK);
      #1;
      total++;
      if ({oDone, oBusy, oParityErr, oFrameErr, oData} !== 12'h000) begin
         bad++;
         $display("FAIL reset_outputs: got %h required %h",
                  {oDone, oBusy, oParityErr, oFrameErr, oData}, 12'h000);
      end
      RESET = 1'b0;
      idle(4);
   endtask

   task automatic test_8n1();
      int d0 = doneCount;
      iParity = 2'b00;
      expQ.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b0});
      sendFrame(8'h55, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      total++;
      if (doneCount - d0 !== 1) begin
         bad++; $display("FAIL 8n1_count: got %0d required 1", doneCount - d0);
      end
      total++;
      if (doneLatency !== HALF + 9 * B + 3) begin
         bad++; $display("FAIL 8n1_latency: got %0d required %0d", doneLatency, HALF + 9 * B + 3);
      end
   endtask

   task automatic test_parity();
      int d0 = doneCount;
      iParity = 2'b01;
      expQ.push_back('{d: 8'hA3, pe: 1'b1, fe: 1'b0});
      sendFrame(8'hA3, 1'b1, 1'b1, 1'b1, -1);
      idle(10);
      expQ.push_back('{d: 8'hA3, pe: 1'b0, fe: 1'b0});
      sendFrame(8'hA3, 1'b1, 1'b0, 1'b1, -1);
      idle(10);
      iParity = 2'b10;
      expQ.push_back('{d: 8'hA3, pe: 1'b0, fe: 1'b0});
      sendFrame(8'hA3, 1'b1, 1'b1, 1'b1, -1);
      idle(10);
      total++;
      if (doneLatency !== HALF + 10 * B + 3) begin
         bad++; $display("FAIL parity_latency: got %0d required %0d", doneLatency, HALF + 10 * B + 3);
      end
      iParity = 2'b11;
      expQ.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
      sendFrame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
      idle(10);
      total++;
      if (doneCount - d0 !== 4) begin
         bad++; $display("FAIL parity_count: got %0d required 4", doneCount - d0);
      end
      iParity = 2'b00;
   endtask

   task automatic test_frame_err();
      int d0 = doneCount;
      expQ.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b1});
      sendFrame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      idle(40);
      expQ.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
      sendFrame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
      idle(10);
      total++;
      if (doneCount - d0 !== 2 || oFrameErr !== 1'b0) begin
         bad++;
         $display("FAIL frame_err_clear: got count=%0d fe=%b required count=2 fe=0",
                  doneCount - d0, oFrameErr);
      end
   endtask

   task automatic test_false_start();
      int   d0 = doneCount;
      logic sawBusy = 1'b0;
      logic lastBusy = 1'b1;
      RXD = 1'b0;
      for (int n = 1; n <= HALF + 3; n++) begin
         @(posedge CLOCK);
         #1;
         if (n == 3) RXD = 1'b1;
         if (oBusy === 1'b1) sawBusy = 1'b1;
         lastBusy = oBusy;
      end
      total++;
      if (sawBusy !== 1'b1 || lastBusy !== 1'b0) begin
         bad++;
         $display("FAIL false_start_busy: got seen=%b final=%b required seen=1 final=0",
                  sawBusy, lastBusy);
      end
      idle(3 * B);
      total++;
      if (doneCount !== d0) begin
         bad++; $display("FAIL false_start_done: got %0d pulses required 0", doneCount - d0);
      end
   endtask

   task automatic test_back_to_back();
      int d0 = doneCount;
      expQ.push_back('{d: 8'hA3, pe: 1'b0, fe: 1'b0});
      expQ.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
      sendFrame(8'hA3, 1'b0, 1'b0, 1'b1, -1);
      sendFrame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
      idle(10);
      total++;
      if (doneCount - d0 !== 2) begin
         bad++; $display("FAIL back_to_back_count: got %0d required 2", doneCount - d0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0 = doneCount;
      sendPartial(8'h00);
      RESET = 1'b1;
      RXD = 1'b1;
      @(posedge CLOCK);
      #1;
      RESET = 1'b0;
      total++;
      if ({oDone, oBusy, oParityErr, oFrameErr, oData} !== 12'h000) begin
         bad++;
         $display("FAIL reset_mid_outputs: got %h required %h",
                  {oDone, oBusy, oParityErr, oFrameErr, oData}, 12'h000);
      end
      idle(12 * B);
      total++;
      if (doneCount !== d0) begin
         bad++; $display("FAIL reset_mid_done: got %0d pulses required 0", doneCount - d0);
      end
      expQ.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0});
      sendFrame(8'h81, 1'b0, 1'b0, 1'b1, -1);
      idle(10);
      total++;
      if (doneCount - d0 !== 1) begin
         bad++; $display("FAIL reset_recover_count: got %0d required 1", doneCount - d0);
      end
   endtask

   task automatic test_icall_abort();
      int d0 = doneCount;
      sendPartial(8'h00);
      iCall = 1'b0;
      RXD = 1'b1;
      repeat (3) @(posedge CLOCK);
      #1;
      total++;
      if ({oDone, oBusy, oParityErr, oFrameErr, oData} !== {4'b0000, 8'h81}) begin
         bad++;
         $display("FAIL icall_abort_outputs: got %h required %h",
                  {oDone, oBusy, oParityErr, oFrameErr, oData}, {4'b0000, 8'h81});
      end
      iCall = 1'b1;
      idle(12 * B);
      total++;
      if (doneCount !== d0) begin
         bad++; $display("FAIL icall_abort_done: got %0d pulses required 0", doneCount - d0);
      end
      expQ.push_back('{d: 8'hC5, pe: 1'b0, fe: 1'b0});
      sendFrame(8'hC5, 1'b0, 1'b0, 1'b1, -1);
      idle(10);
   endtask

   task automatic test_glitch();
      int d0 = doneCount;
      expQ.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b0});
      sendFrame(8'h00, 1'b0, 1'b0, 1'b1, 2);
      idle(10);
      total++;
      if (doneCount - d0 !== 1) begin
         bad++; $display("FAIL glitch_count: got %0d required 1", doneCount - d0);
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_frame_err();
      test_false_start();
      test_back_to_back();
      test_reset_mid_frame();
      test_icall_abort();
`ifdef RX_MAJORITY_EN
      test_glitch();
`endif
      total++;
      if (expQ.size() != 0) begin
         bad++; $display("FAIL missing_done: got %0d frames pending required 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
